// File: rtl/transmissor_ascii_uc_pkg.sv
// -----------------------------------------------------------------------------
// transmissor_ascii_uc_pkg
//   Shared definitions for the ASCII transmitter control unit and its datapath:
//   state codes (shown on db_estado) and the default message geometry.
//   Optional feature macro used by the unit: TX_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package transmissor_ascii_uc_pkg;

   localparam int unsigned N_CHARS_DEF = 8;   // characters per message (D0..D7)
   localparam int unsigned SEL_W_DEF   = 3;   // mux select width

   // State codes double as the debug display value.
   typedef enum logic [3:0] {
      ST_INICIAL   = 4'd0,
      ST_PREPARA   = 4'd1,
      ST_TRANSMITE = 4'd2,
      ST_ESPERA    = 4'd3,
      ST_PROXIMO   = 4'd4,
      ST_FIM       = 4'd5
   } estado_t;

endpackage

// File: rtl/transmissor_ascii_uc_if.sv
// -----------------------------------------------------------------------------
// transmissor_ascii_uc_if
//   Handshake bundle between the requester / serial transmitter side (master)
//   and the control unit (slave).
//   partida   : start request
//   tx_pronto : serial transmitter finished current character
//   sel       : mux select / index of current character
//   transmite : 1-cycle start pulse to the serial transmitter
//   zera_fd   : 1-cycle datapath clear at message start
//   pronto    : 1-cycle message finished (or aborted)
//   ocupado   : unit busy (any state except INICIAL)
//   erro      : sticky timeout flag (only with TX_TIMEOUT_EN)
//   db_estado : current state code
// -----------------------------------------------------------------------------
interface transmissor_ascii_uc_if #(
   parameter int unsigned SEL_W = 3
);
   logic             partida;
   logic             tx_pronto;
   logic [SEL_W-1:0] sel;
   logic             transmite;
   logic             zera_fd;
   logic             pronto;
   logic             ocupado;
   logic             erro;
   logic [3:0]       db_estado;

   modport master (
      output partida, tx_pronto,
      input  sel, transmite, zera_fd, pronto, ocupado, erro, db_estado
   );

   modport slave (
      input  partida, tx_pronto,
      output sel, transmite, zera_fd, pronto, ocupado, erro, db_estado
   );
endinterface

// File: rtl/transmissor_ascii_uc_contador_m.sv
// -----------------------------------------------------------------------------
// contador_m
//   Modulo-M up counter used as the tx_pronto wait timeout.
//   Only built when TX_TIMEOUT_EN is defined (the control unit instantiates it
//   only then).
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   i_zera  : synchronous clear (priority over i_conta)
//   i_conta : count enable
//   o_fim   : count value equals M-1
// -----------------------------------------------------------------------------
`ifdef TX_TIMEOUT_EN
module contador_m #(
   parameter int unsigned M = 16,
   parameter int unsigned N = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_zera,
   input  logic i_conta,
   output logic o_fim
);
   logic [N-1:0] r_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_q <= '0;
      else if (i_zera)
         r_q <= '0;
      else if (i_conta)
         r_q <= (r_q == N'(M - 1)) ? '0 : r_q + N'(1);
   end

   assign o_fim = (r_q == N'(M - 1));
endmodule
`endif

// File: rtl/transmissor_ascii_uc.sv
// -----------------------------------------------------------------------------
// transmissor_ascii_uc
//   Control unit of the 8-character ASCII transmitter (angle + distance, 7O1).
//   One partida sends characters 0..N_CHARS-1: drives sel, pulses transmite,
//   waits tx_pronto per character and pulses pronto at the end.
//   Ports:
//     clock : system clock, rising edge
//     reset : asynchronous active-low reset
//     bus   : transmissor_ascii_uc_if.slave (partida, tx_pronto in;
//             sel, transmite, zera_fd, pronto, ocupado, erro, db_estado out)
//   Macro TX_TIMEOUT_EN: bounds the tx_pronto wait to TIMEOUT_CICLOS clocks
//   and raises the sticky erro flag on expiry. Undefined: erro is tied 0.
// -----------------------------------------------------------------------------
module transmissor_ascii_uc
   import transmissor_ascii_uc_pkg::*;
#(
   parameter int unsigned N_CHARS        = N_CHARS_DEF,
   parameter int unsigned SEL_W          = SEL_W_DEF,
   parameter int unsigned TIMEOUT_CICLOS = 10000,
   parameter int unsigned TMO_W          = 14
) (
   input  logic                   clock,
   input  logic                   reset,
   transmissor_ascii_uc_if.slave  bus
);

   estado_t          r_estado;
   estado_t          w_prox;
   logic [SEL_W-1:0] r_sel;
   logic             w_ultimo;
   logic             w_em_espera;
   logic             w_timeout;

   assign w_ultimo    = (r_sel == SEL_W'(N_CHARS - 1));
   assign w_em_espera = (r_estado == ST_ESPERA);

   // Parameter sanity guard: this block only elaborates for an inconsistent
   // set, making it visible in the hierarchy.
   if (((1 << SEL_W) < N_CHARS) || ((1 << TMO_W) < TIMEOUT_CICLOS)) begin : g_param_invalido
   end

`ifdef TX_TIMEOUT_EN
   logic w_tmo_fim;
   logic r_erro;

   // Cleared in every other state, so it restarts from 0 on each ESPERA entry.
   contador_m #(
      .M (TIMEOUT_CICLOS),
      .N (TMO_W)
   ) u_timeout (
      .i_clk   (clock),
      .i_rst_n (reset),
      .i_zera  (!w_em_espera),
      .i_conta (w_em_espera),
      .o_fim   (w_tmo_fim)
   );

   assign w_timeout = w_em_espera && w_tmo_fim;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_erro <= 1'b0;
      else if (r_estado == ST_PREPARA)
         r_erro <= 1'b0;
      else if (w_timeout && !bus.tx_pronto)
         r_erro <= 1'b1;
   end

   assign bus.erro = r_erro;
`else
   assign w_timeout = 1'b0;
   assign bus.erro  = 1'b0;
`endif

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_estado <= ST_INICIAL;
      else
         r_estado <= w_prox;
   end

   // Next-state logic; tx_pronto takes priority over an expiring timeout.
   always_comb begin
      w_prox = r_estado;
      case (r_estado)
         ST_INICIAL:   if (bus.partida) w_prox = ST_PREPARA;
         ST_PREPARA:   w_prox = ST_TRANSMITE;
         ST_TRANSMITE: w_prox = ST_ESPERA;
         ST_ESPERA: begin
            if (bus.tx_pronto)
               w_prox = w_ultimo ? ST_FIM : ST_PROXIMO;
            else if (w_timeout)
               w_prox = ST_FIM;
         end
         ST_PROXIMO:   w_prox = ST_TRANSMITE;
         ST_FIM:       w_prox = ST_INICIAL;
         default:      w_prox = ST_INICIAL;
      endcase
   end

   // Character index: cleared at message start, advanced between characters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_sel <= '0;
      else if (r_estado == ST_PREPARA)
         r_sel <= '0;
      else if ((r_estado == ST_PROXIMO) && !w_ultimo)
         r_sel <= r_sel + SEL_W'(1);
   end

   // Moore outputs
   assign bus.sel       = r_sel;
   assign bus.zera_fd   = (r_estado == ST_PREPARA);
   assign bus.transmite = (r_estado == ST_TRANSMITE);
   assign bus.pronto    = (r_estado == ST_FIM);
   assign bus.ocupado   = (r_estado != ST_INICIAL);
   assign bus.db_estado = r_estado;

endmodule

// File: tb/tb_transmissor_ascii_uc.sv
module tb_transmissor_ascii_uc;

   localparam int TMO_CFG = 16;
`ifdef TX_TIMEOUT_EN
   localparam int DMAX  = 14;
   localparam int DHELD = 12;
`else
   localparam int DMAX  = 40;
   localparam int DHELD = 20;
`endif
   // Message period with partida held and a fixed responder delay D:
   // zera, 8 chars of (D+2) clocks minus one, FIM, INICIAL -> 8D+18 clocks.
   localparam int PER       = 8 * DHELD + 18;
   localparam int HELD_MSGS = (299 / PER) + 1;

   logic clock;
   logic reset;
   logic r_resp;
   logic r_spur;

   transmissor_ascii_uc_if #(.SEL_W(3)) bus ();
   assign bus.tx_pronto = r_resp | r_spur;

   transmissor_ascii_uc #(
      .N_CHARS        (8),
      .SEL_W          (3),
      .TIMEOUT_CICLOS (TMO_CFG),
      .TMO_W          (14)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc++;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: expected sel per transmite pulse, expected erro per pronto pulse.
   int exp_sel_q[$];
   bit exp_pr_q[$];

   int epoch          = 0;
   int last_resp_edge = 0;
   int last_tx_cyc    = 0;
   int resp_dly       = 0;
   bit spur_in_tx     = 0;
   bit stall          = 0;

   // Serial transmitter model: answers each transmite after a delay.
   initial begin
      int s, d, ep;
      r_resp = 1'b0;
      forever begin
         @(negedge clock);
         if (reset && bus.transmite) begin
            s  = int'(bus.sel);
            ep = epoch;
            d  = (resp_dly != 0) ? resp_dly : int'($urandom_range(2, DMAX));
            if (spur_in_tx) begin
               r_resp = 1'b1;          // seen only at the edge leaving TRANSMITE
               @(posedge clock);
               #1 r_resp = 1'b0;
               d = d - 1;
            end
            if (!(stall && s == 2)) begin
               repeat (d) @(posedge clock);
               #1;
               if (ep == epoch && reset) begin
                  r_resp = 1'b1;
                  last_resp_edge = cyc + 1;
                  @(posedge clock);
                  #1 r_resp = 1'b0;
               end
            end
         end
      end
   end

   // Monitor
   int mon_es;
   bit mon_ee;
   always @(negedge clock) begin
      if (reset) begin
         if (bus.transmite) begin
            if (exp_sel_q.size() == 0)
               check("tx_unexpected", 1, 0);
            else begin
               mon_es = exp_sel_q.pop_front();
               check("tx_sel", int'(bus.sel), mon_es);
               check("tx_erro", int'(bus.erro), 0);
               if (mon_es != 0) check("tx_latency", cyc, last_resp_edge + 1);
            end
            last_tx_cyc = cyc;
         end
         if (bus.pronto) begin
            if (exp_pr_q.size() == 0)
               check("pronto_unexpected", 1, 0);
            else begin
               mon_ee = exp_pr_q.pop_front();
               check("pronto_erro", int'(bus.erro), int'(mon_ee));
               if (mon_ee) check("pronto_tmo_lat", cyc, last_tx_cyc + TMO_CFG + 1);
               else        check("pronto_lat", cyc, last_resp_edge);
            end
         end
      end
   end

   task automatic check_idle(input string n);
      check({n, "_sel"},       int'(bus.sel),       0);
      check({n, "_transmite"}, int'(bus.transmite), 0);
      check({n, "_pronto"},    int'(bus.pronto),    0);
      check({n, "_zera"},      int'(bus.zera_fd),   0);
      check({n, "_ocupado"},   int'(bus.ocupado),   0);
      check({n, "_erro"},      int'(bus.erro),      0);
      check({n, "_estado"},    int'(bus.db_estado), 0);
   endtask

   task automatic expect_msg(input int nchars, input int pr);
      for (int i = 0; i < nchars; i++) exp_sel_q.push_back(i);
      if (pr == 1) exp_pr_q.push_back(1'b0);
      if (pr == 2) exp_pr_q.push_back(1'b1);
   endtask

   task automatic pulse_partida(input int width);
      @(posedge clock);
      #1 bus.partida = 1'b1;
      repeat (width) @(posedge clock);
      #1 bus.partida = 1'b0;
   endtask

   task automatic wait_idle(input string n, input int budget);
      int k = 0;
      @(negedge clock);
      while (bus.ocupado && k < budget) begin
         @(negedge clock);
         k++;
      end
      check({n, "_idle"}, int'(bus.ocupado), 0);
   endtask

   task automatic check_drained(input string n);
      check({n, "_selq"}, exp_sel_q.size(), 0);
      check({n, "_prq"},  exp_pr_q.size(),  0);
   endtask

   task automatic apply_reset(input string n);
      @(negedge clock);
      #2 reset = 1'b0;
      epoch++;
      exp_sel_q.delete();
      exp_pr_q.delete();
      #1 check_idle(n);
      @(negedge clock);
      reset = 1'b1;
      repeat (50) @(negedge clock);
   endtask

   task automatic wait_sel_espera(input string n, input int s);
      int k = 0;
      @(negedge clock);
      while (!(int'(bus.sel) == s && bus.db_estado == 4'd3) && k < 3000) begin
         @(negedge clock);
         k++;
      end
      check({n, "_reached"}, (k < 3000) ? 1 : 0, 1);
   endtask

   initial begin
      int zc, pc, p;
      reset       = 1'b0;
      bus.partida = 1'b0;
      r_spur      = 1'b0;
      #2 check_idle("rst");
      repeat (2) @(negedge clock);
      reset = 1'b1;

      // Full message with latency checks on the start.
      expect_msg(8, 1);
      resp_dly = 20;
      @(posedge clock);
      #1 bus.partida = 1'b1;
      @(posedge clock);
      #1 bus.partida = 1'b0;
      @(negedge clock);
      check("lat_zera", int'(bus.zera_fd), 1);
      check("lat_zera_tx", int'(bus.transmite), 0);
      @(negedge clock);
      check("lat_tx", int'(bus.transmite), 1);
      check("lat_tx_zera", int'(bus.zera_fd), 0);
      wait_idle("msg1", 1000);
      check_drained("msg1");

      // Randomized messages, some with a spurious tx_pronto during TRANSMITE.
      resp_dly = 0;
      for (int m = 0; m < 4; m++) begin
         spur_in_tx = (m % 2) == 1;
         repeat ($urandom_range(0, 10)) @(negedge clock);
         expect_msg(8, 1);
         pulse_partida($urandom_range(1, 3));
         wait_idle("rnd", 2000);
      end
      spur_in_tx = 1'b0;
      check_drained("rnd");

      // Spurious tx_pronto while idle.
      @(posedge clock);
      #1 r_spur = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         check("spur_idle_ocupado", int'(bus.ocupado), 0);
         check("spur_idle_estado", int'(bus.db_estado), 0);
      end
      @(posedge clock);
      #1 r_spur = 1'b0;

      // Reset while waiting on character 5.
      expect_msg(8, 1);
      pulse_partida(1);
      wait_sel_espera("mid", 5);
      apply_reset("midrst");
      expect_msg(8, 1);
      pulse_partida(2);
      wait_idle("after_rst", 2000);
      check_drained("after_rst");

      // partida held for 300 clocks.
      resp_dly = DHELD;
      for (int i = 0; i < HELD_MSGS; i++) expect_msg(8, 1);
      zc = 0; pc = 0; p = 0;
      @(posedge clock);
      #1 bus.partida = 1'b1;
      repeat (300) begin
         @(negedge clock);
         if (bus.pronto) begin pc++; p = cyc; end
         if (bus.zera_fd) begin
            zc++;
            if (pc > 0) check("held_restart", cyc, p + 2);
         end
      end
      @(posedge clock);
      #1 bus.partida = 1'b0;
      wait_idle("held", 2000);
      check("held_msgs", zc, HELD_MSGS);
      check_drained("held");

      // No answer for character 2.
      resp_dly = 0;
      stall    = 1'b1;
`ifdef TX_TIMEOUT_EN
      expect_msg(3, 2);
      pulse_partida(1);
      wait_idle("tmo", 2000);
      stall = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("tmo_erro_sticky", int'(bus.erro), 1);
         @(negedge clock);
      end
      check_drained("tmo");
      // tx_pronto landing on the timeout cycle wins; erro clears on PREPARA.
      resp_dly = TMO_CFG;
      expect_msg(8, 1);
      pulse_partida(1);
      wait_idle("tie", 2000);
      check("tie_erro", int'(bus.erro), 0);
      check_drained("tie");
`else
      expect_msg(3, 0);
      pulse_partida(1);
      wait_sel_espera("stall", 2);
      repeat (100) @(negedge clock);
      check("stall_estado", int'(bus.db_estado), 3);
      check("stall_erro", int'(bus.erro), 0);
      check("stall_ocupado", int'(bus.ocupado), 1);
      check("stall_sel", int'(bus.sel), 2);
      check_drained("stall");
      stall = 1'b0;
      apply_reset("stallrst");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
